axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI slave backed by a word-addressed SRAM.
// One read or write burst is in flight at a time. Bursts are incrementing and
// wrap modulo DEPTH_WORDS. Reads are served combinationally from the array, so
// there are zero wait states. Protocol violations are recorded in a sticky flag
// and never change how a burst is sequenced.
module axi_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  // write address channel
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [3:0]            awid,
  input  logic [3:0]            awlen,
  input  logic [ADDR_WIDTH-1:0] awaddr,

  // write data channel
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  input  logic [3:0]            wid,
  input  logic [DATA_WIDTH-1:0] wdata,

  // write response channel
  output logic                  bvalid,
  input  logic                  bready,
  output logic [3:0]            bid,

  // read address channel
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [3:0]            arid,
  input  logic [3:0]            arlen,
  input  logic [ADDR_WIDTH-1:0] araddr,

  // read data channel
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  rlast,
  output logic [3:0]            rid,
  output logic [DATA_WIDTH-1:0] rdata,

  output logic                  proto_err
);

  // Word-index width; the byte address is sliced at [IDX_W+1:2].
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_DATA  = 2'd2,
    WR_RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Per-burst context. A single set of registers serves both directions
  // because only one transaction is ever outstanding.
  logic [IDX_W-1:0]      cur_addr;
  logic [3:0]            beat_cnt;
  logic [3:0]            len_q;
  logic [3:0]            id_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic aw_hs, ar_hs, w_hs, r_hs;
  logic last_beat;
  logic aw_misaligned, ar_misaligned, w_bad_last, w_bad_id;

  // High address bits beyond the array are ignored; fold them into one
  // unused net so they are visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:IDX_W+2],
                              araddr[ADDR_WIDTH-1:IDX_W+2]};

  assign last_beat = (beat_cnt == len_q);

  assign aw_hs = awvalid & awready;
  assign ar_hs = arvalid & arready;
  assign w_hs  = wvalid  & wready;
  assign r_hs  = rvalid  & rready;

  assign aw_misaligned = (awaddr[1:0] != 2'b00);
  assign ar_misaligned = (araddr[1:0] != 2'b00);
  // The slave's own beat count decides where the burst ends; the master's
  // WLAST is only cross-checked against it.
  assign w_bad_last    = (wlast != last_beat);
  assign w_bad_id      = (wid != id_q);

  // State register; reset drops straight to IDLE so all valids fall at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and channel handshake signals; write wins a tie with read.
  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    case (state)
      IDLE: begin
        awready = 1'b1;
        arready = ~awvalid;
        if (awvalid)      state_nxt = WR_DATA;
        else if (arvalid) state_nxt = RD_BURST;
      end
      RD_BURST: begin
        rvalid = 1'b1;
        if (rready && last_beat) state_nxt = IDLE;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid && last_beat) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst context: latch on the address handshake, advance on each data beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      id_q     <= '0;
    end else if (aw_hs) begin
      cur_addr <= awaddr[IDX_W+1:2];
      beat_cnt <= '0;
      len_q    <= awlen;
      id_q     <= awid;
    end else if (ar_hs) begin
      cur_addr <= araddr[IDX_W+1:2];
      beat_cnt <= '0;
      len_q    <= arlen;
      id_q     <= arid;
    end else if (w_hs || r_hs) begin
      // Power-of-two depth: natural overflow gives the wrap to word 0.
      cur_addr <= cur_addr + 1'b1;
      beat_cnt <= beat_cnt + 4'd1;
    end
  end

  // Sticky protocol-error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((aw_hs && aw_misaligned) ||
                 (ar_hs && ar_misaligned) ||
                 (w_hs && (w_bad_last || w_bad_id))) begin
      err_q <= 1'b1;
    end
  end

  // Storage write port. w_hs needs WR_DATA, which reset forces away from,
  // so no write can land while reset is asserted. Contents survive reset.
  always_ff @(posedge clk) begin
    if (w_hs) mem[cur_addr] <= wdata;
  end

  // Read data comes straight from the array at the current word, so it is
  // stable for as long as the beat is stalled.
  assign rdata     = rvalid ? mem[cur_addr] : '0;
  assign rlast     = rvalid & last_beat;
  assign rid       = rvalid ? id_q : 4'd0;
  assign bid       = bvalid ? id_q : 4'd0;
  assign proto_err = err_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed plus randomized bursts against a flat word-array
// reference model. Inputs change on the falling edge; outputs are sampled 1ns
// later, well away from the rising edge that commits handshakes.
module tb_axi_sram_slave;

  localparam int D = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [3:0]  awid, awlen;
  logic [31:0] awaddr;
  logic        wvalid, wready, wlast;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [3:0]  arid, arlen;
  logic [31:0] araddr;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        proto_err;

  axi_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(D)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wid(wid), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bid(bid),
    .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid), .rdata(rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference memory and the context of the burst currently being driven.
  logic [31:0] mdl [D];
  int          cur_base;
  int          cur_len;
  logic [3:0]  cur_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ctx(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id);
    cur_base = int'(addr[11:2]);
    cur_len  = int'(len);
    cur_id   = id;
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id);
    awvalid = 1'b1; awaddr = addr; awlen = len; awid = id;
    #1;
    check("awready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    set_ctx(addr, len, id);
  endtask

  // bad_last: beat index whose WLAST is inverted (-1 for none).
  task automatic w_phase(input int bad_last, input logic bad_wid, input logic rnd,
                         input logic [31:0] dbase);
    int gap;
    for (int i = 0; i <= cur_len; i++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        wvalid = 1'b0;
        #1;
        check("wready_gap", wready, 1);
        @(negedge clk);
      end
      wvalid = 1'b1;
      wid    = bad_wid ? ~cur_id : cur_id;
      wlast  = (i == cur_len) ^ (i == bad_last);
      wdata  = rnd ? $urandom : dbase + 32'(i);
      #1;
      check("wready", wready, 1);
      mdl[(cur_base + i) % D] = wdata;
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic b_phase();
    int gap;
    gap = int'($urandom_range(0, 2));
    for (int g = 0; g < gap; g++) begin
      bready = 1'b0;
      #1;
      check("bvalid_wait", bvalid, 1);
      check("bid_wait", bid, cur_id);
      @(negedge clk);
    end
    bready = 1'b1;
    #1;
    check("bvalid", bvalid, 1);
    check("bid", bid, cur_id);
    @(negedge clk);
    bready = 1'b0;
    #1;
    check("bvalid_done", bvalid, 0);
    check("awready_after_b", awready, 1);
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id);
    arvalid = 1'b1; araddr = addr; arlen = len; arid = id;
    #1;
    check("arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    set_ctx(addr, len, id);
  endtask

  // rpat bit (cycle % 32) drives RREADY; stop_at >= 0 leaves the burst
  // open with that beat presented.
  task automatic r_phase(input logic [31:0] rpat, input int stop_at);
    int beat, cyc;
    beat = 0;
    cyc  = 0;
    while (beat <= cur_len && beat != stop_at && cyc < 300) begin
      rready = rpat[cyc % 32];
      #1;
      check("rvalid", rvalid, 1);
      check("rid", rid, cur_id);
      check("rdata", rdata, mdl[(cur_base + beat) % D]);
      check("rlast", rlast, (beat == cur_len) ? 1 : 0);
      if (rready) beat++;
      cyc++;
      @(negedge clk);
    end
    rready = 1'b0;
    if (stop_at < 0) begin
      check("r_beats", beat, cur_len + 1);
      #1;
      check("rvalid_done", rvalid, 0);
    end else begin
      check("r_beats_partial", beat, stop_at);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input logic rnd, input logic [31:0] dbase);
    aw_phase(addr, len, id);
    w_phase(-1, 1'b0, rnd, dbase);
    b_phase();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                         input logic [31:0] rpat);
    ar_phase(addr, len, id);
    r_phase(rpat, -1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("proto_err_cleared", proto_err, 0);
  endtask

  function automatic logic [31:0] rnd_pat();
    return $urandom | 32'h1111_1111;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awvalid = 0; awid = 0; awlen = 0; awaddr = 0;
    wvalid = 0; wlast = 0; wid = 0; wdata = 0; bready = 0;
    arvalid = 0; arid = 0; arlen = 0; araddr = 0; rready = 0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bid", bid, 0);
    check("rst_rid", rid, 0);
    check("rst_proto_err", proto_err, 0);
    awvalid = 1'b1;
    #1;
    check("rst_arready_awvalid", arready, 0);
    awvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Basic write burst and read-back.
    do_write(32'h40, 4'd3, 4'd5, 1'b0, 32'hA0);
    do_read(32'h40, 4'd3, 4'd2, 32'hFFFF_FFFF);

    // RREADY 1,0,0,1 stall pattern.
    do_read(32'h40, 4'd3, 4'd7, 32'h9999_9999);

    // AW and AR together: write first, AR held off until B completes.
    awvalid = 1'b1; awaddr = 32'h80; awlen = 4'd1; awid = 4'd6;
    arvalid = 1'b1; araddr = 32'h40; arlen = 4'd3; arid = 4'd9;
    #1;
    check("tie_awready", awready, 1);
    check("tie_arready", arready, 0);
    @(negedge clk);
    awvalid = 1'b0;
    set_ctx(32'h80, 4'd1, 4'd6);
    #1;
    check("tie_arready_wdata", arready, 0);
    w_phase(-1, 1'b0, 1'b1, 32'h0);
    #1;
    check("tie_arready_wresp", arready, 0);
    b_phase();
    check("tie_arready_idle", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    set_ctx(32'h40, 4'd3, 4'd9);
    r_phase(rnd_pat(), -1);

    // Wrap at the top of the array.
    do_write(32'hFF8, 4'd3, 4'd3, 1'b1, 32'h0);
    do_read(32'hFF8, 4'd3, 4'd4, rnd_pat());
    do_read(32'h0, 4'd1, 4'd6, rnd_pat());

    // Randomized write/read-back pairs.
    for (int n = 0; n < 12; n++) begin
      logic [31:0] a;
      logic [3:0]  l;
      a = {20'd0, 10'($urandom_range(0, D - 1)), 2'b00};
      l = 4'($urandom_range(0, 15));
      do_write(a, l, 4'($urandom), 1'b1, 32'h0);
      do_read(a, l, 4'($urandom), rnd_pat());
    end
    check("proto_err_clean", proto_err, 0);

    // Early WLAST: still two beats accepted, then B.
    aw_phase(32'h100, 4'd1, 4'hA);
    w_phase(0, 1'b0, 1'b1, 32'h0);
    b_phase();
    check("proto_err_wlast", proto_err, 1);
    pulse_reset();

    // WID mismatch.
    aw_phase(32'h200, 4'd2, 4'd3);
    w_phase(-1, 1'b1, 1'b1, 32'h0);
    b_phase();
    check("proto_err_wid", proto_err, 1);
    pulse_reset();

    // Misaligned AWADDR, then misaligned ARADDR.
    do_write(32'h302, 4'd0, 4'd1, 1'b1, 32'h0);
    check("proto_err_awaddr", proto_err, 1);
    pulse_reset();
    do_read(32'h301, 4'd0, 4'd2, 32'hFFFF_FFFF);
    check("proto_err_araddr", proto_err, 1);
    pulse_reset();
    do_read(32'h100, 4'd1, 4'd2, rnd_pat());
    check("proto_err_single_rd", proto_err, 0);

    // Reset during beat 2 of an 8-beat read.
    do_write(32'h500, 4'd7, 4'd1, 1'b1, 32'h0);
    ar_phase(32'h500, 4'd7, 4'd2);
    r_phase(32'hFFFF_FFFF, 2);
    rst = 1'b1;
    #1;
    check("abort_rvalid", rvalid, 0);
    check("abort_rlast", rlast, 0);
    check("abort_rid", rid, 0);
    check("abort_awready", awready, 1);
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h500, 4'd7, 4'd3, rnd_pat());

    // Reset during a write burst: the held beat must not land.
    aw_phase(32'h500, 4'd7, 4'd4);
    wvalid = 1'b1; wid = 4'd4; wlast = 1'b0; wdata = $urandom;
    #1;
    check("abort_w_wready", wready, 1);
    mdl[cur_base] = wdata;
    @(negedge clk);
    wdata = $urandom;
    rst = 1'b1;
    #1;
    check("abort_w_wready_rst", wready, 0);
    @(negedge clk);
    rst = 1'b0;
    wvalid = 1'b0;
    do_read(32'h500, 4'd7, 4'd5, rnd_pat());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
